adder_word_sequencer: RTL and testbench

- Controller that performs NWORDS×WORD_W-bit add/subtract by time-multiplexing one external WORD_W-bit carry-in/carry-out adder (the 16-bit x/y/c0 → s/c4 adder), one word per cycle, least-significant word first.
- Latches operands on a start pulse, drives the adder's x/y/c0 each cycle, captures s/c4 and chains the carry.
- Reports the wide sum, carry-out and signed overflow with a done pulse.
- Sits between the operand source and the shared adder instance.

---
 rtl/adder_word_sequencer.sv | 109 ++++++++++
 tb/tb_adder_word_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/adder_word_sequencer.sv
// Word-serial wide add/subtract controller driving one shared WORD_W-bit adder.
// Processes least-significant word first and chains the carry between cycles.
module adder_word_sequencer #(
   parameter int WORD_W = 16,
   parameter int NWORDS = 4,
   localparam int W = WORD_W * NWORDS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              sub,
   input  logic              cin,
   input  logic [W-1:0]      a,
   input  logic [W-1:0]      b,
   output logic [WORD_W-1:0] add_x,
   output logic [WORD_W-1:0] add_y,
   output logic              add_c0,
   input  logic [WORD_W-1:0] add_s,
   input  logic              add_c4,
   output logic              busy,
   output logic              done,
   output logic [W-1:0]      sum,
   output logic              cout,
   output logic              ovf
);

   localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [W-1:0]     a_r, b_r;
   logic [W-1:0]     shadow, shadow_nx;
   logic             last;

   assign last = (idx == IDX_W'(NWORDS - 1));
   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      add_x    = '0;
      add_y    = '0;
      add_c0   = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            add_x  = a_r[int'(idx)*WORD_W +: WORD_W];
            add_y  = b_r[int'(idx)*WORD_W +: WORD_W];
            add_c0 = carry;
            if (last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Shadow with the current word merged in; copied to sum only on the last word.
   always_comb begin
      shadow_nx = shadow;
      shadow_nx[int'(idx)*WORD_W +: WORD_W] = add_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         carry  <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         shadow <= '0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               shadow <= shadow_nx;
               carry  <= add_c4;
               if (last) begin
                  sum  <= shadow_nx;
                  cout <= add_c4;
                  ovf  <= (a_r[W-1] == b_r[W-1]) && (add_s[WORD_W-1] != a_r[W-1]);
                  done <= 1'b1;
                  idx  <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: idx <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Directed bench for adder_word_sequencer with a behavioural 16-bit adder attached.
module tb_adder_word_sequencer;

   localparam int WORD_W = 16;
   localparam int NWORDS = 4;
   localparam int W      = WORD_W * NWORDS;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, sub, cin;
   logic [W-1:0]      a, b;
   logic [WORD_W-1:0] add_x, add_y, add_s;
   logic              add_c0, add_c4;
   logic              busy, done, cout, ovf;
   logic [W-1:0]      sum;
   logic [WORD_W:0]   add_full;
   logic [NWORDS-1:0] c0_log;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign add_full = {1'b0, add_x} + {1'b0, add_y} + {{WORD_W{1'b0}}, add_c0};
   assign add_s    = add_full[WORD_W-1:0];
   assign add_c4   = add_full[WORD_W];

   adder_word_sequencer #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
      .a(a), .b(b), .add_x(add_x), .add_y(add_y), .add_c0(add_c0),
      .add_s(add_s), .add_c4(add_c4), .busy(busy), .done(done),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Pulse start for one edge; returns at the negedge of RUN cycle 0.
   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input logic cv);
      a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~av; b = ~bv; sub = ~sv; cin = ~cv;
   endtask

   task automatic run_cycles(input string tag);
      for (int i = 0; i < NWORDS; i++) begin
         c0_log[i] = add_c0;
         check({tag, "_busy"}, W'(busy), W'(1));
         check({tag, "_nodone"}, W'(done), W'(0));
         @(negedge clk);
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] es,
                               input logic ec, input logic eo);
      check({tag, "_done"}, W'(done), W'(1));
      check({tag, "_idle"}, W'(busy), W'(0));
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, W'(cout), W'(ec));
      check({tag, "_ovf"}, W'(ovf), W'(eo));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      #1;
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      check("rst_sum", sum, '0);
      check("rst_addx", W'(add_x), W'(0));
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      launch(64'h0000_0000_0000_1A33, 64'h0000_0000_0000_E5EB, 1'b0, 1'b0);
      run_cycles("add1");
      check_result("add1", 64'h0000_0000_0001_001E, 1'b0, 1'b0);
      check("add1_c0_cyc2", W'(c0_log[1]), W'(1));
      @(negedge clk);
      check("add1_pulse", W'(done), W'(0));
      check("add1_hold", sum, 64'h0000_0000_0001_001E);
      check("idle_addx", W'(add_x), W'(0));

      launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      run_cycles("rip");
      check_result("rip", 64'h0, 1'b1, 1'b0);
      check("rip_c0", W'(c0_log), W'(4'b1110));
      @(negedge clk);

      launch(64'd5, 64'd7, 1'b1, 1'b0);
      run_cycles("sub1");
      check_result("sub1", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      @(negedge clk);

      launch(64'd7, 64'd5, 1'b1, 1'b0);
      run_cycles("sub2");
      check_result("sub2", 64'd2, 1'b1, 1'b0);
      @(negedge clk);

      launch(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      run_cycles("ovf");
      check_result("ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      @(negedge clk);

      // Re-pulse start at T+2 with other operands: must be ignored.
      launch(64'd3, 64'd4, 1'b0, 1'b0);
      @(negedge clk);
      a = 64'd100; b = 64'd200; sub = 1'b0; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy", W'(busy), W'(1));
      @(negedge clk); @(negedge clk);
      check_result("ign", 64'd7, 1'b0, 1'b0);
      @(negedge clk);
      check("ign_pulse", W'(done), W'(0));
      check("ign_idle", W'(busy), W'(0));

      // Start in the done cycle: second done 5 cycles after the first.
      launch(64'd1, 64'd2, 1'b0, 1'b1);
      run_cycles("b2b1");
      check_result("b2b1", 64'd4, 1'b0, 1'b0);
      launch(64'd10, 64'd20, 1'b0, 1'b0);
      check("b2b_gap", W'(done), W'(0));
      run_cycles("b2b2");
      check_result("b2b2", 64'd30, 1'b0, 1'b0);
      @(negedge clk);

      // Asynchronous reset mid-operation.
      launch(64'd9, 64'd9, 1'b0, 1'b0);
      @(negedge clk); @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", W'(busy), W'(0));
      check("arst_done", W'(done), W'(0));
      check("arst_sum", sum, '0);
      check("arst_cout", W'(cout), W'(0));
      check("arst_ovf", W'(ovf), W'(0));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("arst_nodone", W'(done), W'(0));
         if (i == 2) rst_n = 1'b1;
      end
      launch(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 1'b1);
      run_cycles("post");
      check_result("post", 64'h0011_0022_0033_0045, 1'b0, 1'b0);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
